mips_pipe_ctrl: RTL

//  Central pipeline controller for the 5-stage MIPS core: forwarding selects, load-use stall, branch flush, run/step/halt.

---
 rtl/mips_pipe_ctrl_pkg.sv | 19 +
 rtl/mips_pipe_ctrl_if.sv | 66 ++++++
 rtl/mips_pipe_ctrl_fwd_sel.sv | 35 +++
 rtl/mips_pipe_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mips_pipe_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline controller.
// State encodings, forwarding select codes and drain length.
package mips_pipe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int DRAIN_CYCLES = 3;

endpackage

// File: rtl/mips_pipe_ctrl_if.sv
// Bundle between the pipeline controller and the datapath stages.
// master = stages/debug side, slave = controller.
interface mips_pipe_ctrl_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
);

  logic            Run_Start;
  logic            Step_Req;
  logic            Halt_Req;
  logic            HaltInstr_ID;
  logic [RA_W-1:0] RS_ID;
  logic [RA_W-1:0] RT_ID;
  logic            UsesRT_ID;
  logic            BranchTaken_ID;
  logic [RA_W-1:0] RS_EX;
  logic [RA_W-1:0] RT_EX;
  logic            MemRead_EX;
  logic            RegWrite_EX;
  logic            RegWrite_MEM;
  logic            RegWrite_WB;
  logic [RA_W-1:0] RegDst_EX;
  logic [RA_W-1:0] RegDst_MEM;
  logic [RA_W-1:0] RegDst_WB;

  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEXBubble;
  logic             Flush_IF;
  logic             PipeEnable;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic [2:0]       State;
  logic             Halted;
  logic [CNT_W-1:0] CycleCount;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output Run_Start, Step_Req, Halt_Req,
    output HaltInstr_ID, RS_ID, RT_ID,
    output UsesRT_ID, BranchTaken_ID,
    output RS_EX, RT_EX, MemRead_EX,
    output RegWrite_EX, RegWrite_MEM,
    output RegWrite_WB, RegDst_EX,
    output RegDst_MEM, RegDst_WB,
    input  PCWrite, IFIDWrite, IDEXBubble,
    input  Flush_IF, PipeEnable,
    input  ForwardA, ForwardB, State,
    input  Halted, CycleCount, StallCount
  );

  modport slave (
    input  Run_Start, Step_Req, Halt_Req,
    input  HaltInstr_ID, RS_ID, RT_ID,
    input  UsesRT_ID, BranchTaken_ID,
    input  RS_EX, RT_EX, MemRead_EX,
    input  RegWrite_EX, RegWrite_MEM,
    input  RegWrite_WB, RegDst_EX,
    input  RegDst_MEM, RegDst_WB,
    output PCWrite, IFIDWrite, IDEXBubble,
    output Flush_IF, PipeEnable,
    output ForwardA, ForwardB, State,
    output Halted, CycleCount, StallCount
  );

endinterface

// File: rtl/mips_pipe_ctrl_fwd_sel.sv
// EX operand forwarding select for one source register.
// MEM result is younger than WB, so it wins when both match.
module fwd_sel
  import mips_pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] srcReg,
  input  logic            regWriteMem,
  input  logic [RA_W-1:0] dstMem,
  input  logic            regWriteWb,
  input  logic [RA_W-1:0] dstWb,
  output logic [1:0]      fwd
);

  logic memHit;
  logic wbHit;

  assign memHit = regWriteMem
                & (dstMem != '0)
                & (dstMem == srcReg);
  assign wbHit  = regWriteWb
                & (dstWb != '0)
                & (dstWb == srcReg);

  always_comb begin
    fwd = FWD_RF;
    priority case (1'b1)
      memHit:  fwd = FWD_MEM;
      wbHit:   fwd = FWD_WB;
      default: fwd = FWD_RF;
    endcase
  end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipeline controller: forwarding, load-use stall, branch flush,
// debug run control and cycle/stall performance counters.
module mips_pipe_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int RA_W       = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input logic            Clock,
  input logic            Reset,
  mips_pipe_ctrl_if.slave bus
);

  localparam logic [2:0] RELOAD = 3'(LOAD_STALL - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_t           state;
  state_t           stateNxt;
  logic [2:0]       stallCnt;
  logic [1:0]       drainCnt;
  logic [CNT_W-1:0] cycleCnt;
  logic [CNT_W-1:0] stallTot;

  logic active;
  logic enabled;
  logic hazard;
  logic stall;

  fwd_sel #(.RA_W(RA_W)) uFwdA (
    .srcReg      (bus.RS_EX),
    .regWriteMem (bus.RegWrite_MEM),
    .dstMem      (bus.RegDst_MEM),
    .regWriteWb  (bus.RegWrite_WB),
    .dstWb       (bus.RegDst_WB),
    .fwd         (bus.ForwardA)
  );

  fwd_sel #(.RA_W(RA_W)) uFwdB (
    .srcReg      (bus.RT_EX),
    .regWriteMem (bus.RegWrite_MEM),
    .dstMem      (bus.RegDst_MEM),
    .regWriteWb  (bus.RegWrite_WB),
    .dstWb       (bus.RegDst_WB),
    .fwd         (bus.ForwardB)
  );

  assign active  = (state == ST_RUN)
                 | (state == ST_STEP);
  assign enabled = active | (state == ST_DRAIN);

  assign hazard = bus.MemRead_EX
                & (bus.RegDst_EX != '0)
                & ((bus.RegDst_EX == bus.RS_ID)
                 | (bus.UsesRT_ID
                  & (bus.RegDst_EX == bus.RT_ID)));

  assign stall = active
               & (hazard | (stallCnt != '0));

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.Halt_Req)       stateNxt = ST_IDLE;
        else if (bus.Step_Req)  stateNxt = ST_STEP;
        else if (bus.Run_Start) stateNxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.Halt_Req)
          stateNxt = ST_IDLE;
        else if (bus.HaltInstr_ID && !stall)
          stateNxt = ST_DRAIN;
      end
      ST_STEP: begin
        if (bus.HaltInstr_ID && !stall)
          stateNxt = ST_DRAIN;
        else
          stateNxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (drainCnt == DRAIN_LAST)
          stateNxt = ST_HALTED;
      end
      ST_HALTED: stateNxt = ST_HALTED;
      default:   stateNxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.IFIDWrite  = 1'b0;
    bus.IDEXBubble = 1'b0;
    bus.Flush_IF   = 1'b0;
    bus.PipeEnable = enabled;
    unique case (1'b1)
      active: begin
        bus.PCWrite    = !stall;
        bus.IFIDWrite  = !stall;
        bus.IDEXBubble = stall;
        bus.Flush_IF   = bus.BranchTaken_ID
                       & !stall;
      end
      // HALT sits frozen in ID while older work retires
      (state == ST_DRAIN): begin
        bus.IDEXBubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      stallCnt <= '0;
    end else if (active) begin
      if (stallCnt != '0)
        stallCnt <= stallCnt - 3'd1;
      else if (hazard)
        stallCnt <= RELOAD;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      drainCnt <= '0;
    end else if (state == ST_DRAIN) begin
      drainCnt <= drainCnt + 2'd1;
    end else begin
      drainCnt <= '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cycleCnt <= '0;
      stallTot <= '0;
    end else begin
      if (enabled && (cycleCnt != '1))
        cycleCnt <= cycleCnt + 1'b1;
      if (stall && (stallTot != '1))
        stallTot <= stallTot + 1'b1;
    end
  end

  assign bus.State      = state;
  assign bus.Halted     = (state == ST_HALTED);
  assign bus.CycleCount = cycleCnt;
  assign bus.StallCount = stallTot;

endmodule
